// File: rtl/tcm_arb_pkg.sv
// Shared types and helpers for the TCM arbiter: port index type,
// per-transaction response record and address alignment check.
package tcm_arb_pkg;

  localparam int NUM_PORTS_MAX = 8;
  localparam int PORT_IDX_W    = $clog2(NUM_PORTS_MAX);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } resp_t;

  // True when the byte address is not aligned to a full data word.
  function automatic logic is_misaligned(input logic [31:0] addr, input int data_width);
    logic [31:0] mask;
    mask = 32'(data_width / 8) - 32'd1;
    return (addr & mask) != 32'd0;
  endfunction

endpackage

// File: rtl/tcm_rr_arb.sv
// Combinational round-robin picker with an owner-hold override.
// Holds no state; the top level owns the pointer and lock owner.
module tcm_rr_arb
  import tcm_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            ptr_i,
  input  logic                 lock_valid_i,
  input  port_idx_t            owner_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            winner_o,
  output logic                 valid_o
);

  // Owner hold first, then scan from ptr upward, then wrap to the low ports.
  always_comb begin
    gnt_o    = {NUM_PORTS{1'b0}};
    winner_o = port_idx_t'(0);
    valid_o  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (lock_valid_i && (owner_i == port_idx_t'(i)) && req_i[i]) begin
        gnt_o[i] = 1'b1;
        winner_o = port_idx_t'(i);
        valid_o  = 1'b1;
      end else begin
        valid_o  = valid_o;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!valid_o && req_i[i] && (port_idx_t'(i) >= ptr_i)) begin
        gnt_o[i] = 1'b1;
        winner_o = port_idx_t'(i);
        valid_o  = 1'b1;
      end else begin
        valid_o  = valid_o;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!valid_o && req_i[i]) begin
        gnt_o[i] = 1'b1;
        winner_o = port_idx_t'(i);
        valid_o  = 1'b1;
      end else begin
        valid_o  = valid_o;
      end
    end
  end

endmodule

// File: rtl/tcm_arbiter.sv
// Shares one single-port TCM between NUM_PORTS requesters with
// round-robin arbitration, optional burst lock and 1-cycle responses.
module tcm_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic                              tcm_en_o,
  output logic [ADDR_WIDTH-1:0]             tcm_addr_o,
  output logic [DATA_WIDTH-1:0]             tcm_wdata_o,
  output logic                              tcm_we_o,
  output logic [DATA_WIDTH/8-1:0]           tcm_be_o,
  input  logic [DATA_WIDTH-1:0]             tcm_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  port_idx_t             rr_ptr_q, rr_ptr_d;
  port_idx_t             owner_q, owner_d;
  logic                  owner_valid_q, owner_valid_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]  err_q, err_d;
  resp_t                 resp_q, resp_d;

  logic [NUM_PORTS-1:0]  gnt_s;
  port_idx_t             winner_s;
  logic                  win_valid_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [BE_W-1:0]       sel_be_s;
  logic                  sel_we_s;
  logic                  sel_lock_s;
  logic                  misaligned_s;

  tcm_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arb (
    .req_i        (req_i),
    .ptr_i        (rr_ptr_q),
    .lock_valid_i (owner_valid_q),
    .owner_i      (owner_q),
    .gnt_o        (gnt_s),
    .winner_o     (winner_s),
    .valid_o      (win_valid_s)
  );

  // Select the winning port's payload; zeros when nobody wins.
  always_comb begin
    sel_addr_s  = {ADDR_WIDTH{1'b0}};
    sel_wdata_s = {DATA_WIDTH{1'b0}};
    sel_be_s    = {BE_W{1'b0}};
    sel_we_s    = 1'b0;
    sel_lock_s  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_valid_s && (winner_s == port_idx_t'(i))) begin
        sel_addr_s  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be_s    = be_i[i*BE_W +: BE_W];
        sel_we_s    = we_i[i];
        sel_lock_s  = lock_i[i];
      end else begin
        sel_we_s    = sel_we_s;
      end
    end
    misaligned_s = win_valid_s && is_misaligned(32'(sel_addr_s), DATA_WIDTH);
  end

  // Next pointer, lock ownership and response pipeline.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    owner_valid_d = 1'b0;
    if (win_valid_s) begin
      if (winner_s == port_idx_t'(NUM_PORTS - 1)) begin
        rr_ptr_d = port_idx_t'(0);
      end else begin
        rr_ptr_d = winner_s + port_idx_t'(1);
      end
      owner_valid_d = sel_lock_s;
      owner_d       = sel_lock_s ? winner_s : owner_q;
    end else begin
      rr_ptr_d      = rr_ptr_q;
    end
    rvalid_d     = gnt_s;
    err_d        = gnt_s & {NUM_PORTS{misaligned_s}};
    resp_d.valid = win_valid_s;
    resp_d.we    = sel_we_s;
    resp_d.err   = misaligned_s;
  end

  // State registers; a reset drops any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= port_idx_t'(0);
      owner_q       <= port_idx_t'(0);
      owner_valid_q <= 1'b0;
      rvalid_q      <= {NUM_PORTS{1'b0}};
      err_q         <= {NUM_PORTS{1'b0}};
      resp_q        <= 3'b000;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      rvalid_q      <= rvalid_d;
      err_q         <= err_d;
      resp_q        <= resp_d;
    end
  end

  // Drive grants and the TCM; misaligned accesses are granted but never reach the TCM.
  always_comb begin
    gnt_o       = {NUM_PORTS{1'b0}};
    tcm_en_o    = 1'b0;
    tcm_we_o    = 1'b0;
    tcm_addr_o  = sel_addr_s;
    tcm_wdata_o = sel_wdata_s;
    tcm_be_o    = sel_be_s;
    if (rst_ni) begin
      gnt_o    = gnt_s;
      tcm_en_o = win_valid_s & ~misaligned_s;
      tcm_we_o = win_valid_s & sel_we_s & ~misaligned_s;
    end else begin
      gnt_o    = {NUM_PORTS{1'b0}};
    end
    rvalid_o = rvalid_q;
    err_o    = err_q;
    if (resp_q.valid && !resp_q.we && !resp_q.err) begin
      rdata_o = tcm_rdata_i;
    end else begin
      rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: doc/tcm_arbiter.md
Name: tcm_arbiter

Overview:
- Shares one single-port TCM (1-cycle registered read latency, byte enables, byte address aligned to DATA_WIDTH) between NUM_PORTS requesters, e.g. port 0 = core LSU, port 1 = DMA/debug.
- Uses a req/gnt/rvalid handshake, round-robin arbitration and an optional per-port lock for back-to-back bursts.
- Sits between the requesters and the TCM wrapper; drives the wrapper's en/addr/wdata/we/be directly and steers its read data back to the owning port.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 15, byte address width (default matches 8192 x 32-bit TCM).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- lock_i  in  NUM_PORTS  per-port request to keep ownership after the current grant.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address, packed with port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data, packed.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, packed.
- gnt_o  out  NUM_PORTS  one-hot grant; the request is accepted this cycle.
- rvalid_o  out  NUM_PORTS  one-hot response, one cycle after gnt, for reads and writes.
- rdata_o  out  DATA_WIDTH  read data, valid only while any rvalid_o bit is high.
- err_o  out  NUM_PORTS  misaligned-address flag, coincident with rvalid_o.
- tcm_en_o  out  1  TCM enable.
- tcm_addr_o  out  ADDR_WIDTH  TCM byte address.
- tcm_wdata_o  out  DATA_WIDTH  TCM write data.
- tcm_we_o  out  1  TCM write enable.
- tcm_be_o  out  DATA_WIDTH/8  TCM byte enables.
- tcm_rdata_i  in  DATA_WIDTH  TCM read data, registered inside the TCM.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - rr_ptr=0, owner_valid=0, rvalid_q=0, err_q=0.
  - gnt_o, tcm_en_o, rvalid_o and err_o are held 0 while rst_ni is low; gnt_o and tcm_en_o are combinationally gated by rst_ni.
- Grant (combinational, same cycle as req):
  - If owner_valid and req_i[owner], grant owner (lock hold).
  - Otherwise grant the first set req_i scanning from rr_ptr upward, wrapping at NUM_PORTS.
  - At most one gnt_o bit is set. gnt_o[p] implies req_i[p].
- TCM drive:
  - tcm_en_o = |gnt_o.
  - tcm_addr/wdata/we/be are muxed from the winner.
  - Misaligned accesses (addr low log2(DATA_WIDTH/8) bits != 0) are granted, but force tcm_en_o=0 and tcm_we_o=0.
  - With no winner, tcm_addr/wdata/be drive 0 and tcm_we_o=0.
- Pointer update on any grant to port w: rr_ptr <= (w+1) mod NUM_PORTS, wrap-around included. No grant leaves rr_ptr unchanged.
- Lock:
  - On a grant to w with lock_i[w]=1: owner<=w, owner_valid<=1.
  - On a grant with lock_i[w]=0: owner_valid<=0.
  - A cycle where the owner does not request clears owner_valid, and normal round-robin applies that same cycle.
- Response:
  - rvalid_q <= gnt_o; rvalid_o = rvalid_q.
  - err_q[p] <= gnt_o[p] & misaligned; err_o = err_q.
  - rdata_o = tcm_rdata_i when the response is a non-error read, else 0.
  - Latency: gnt at cycle N gives rvalid at N+1. Throughput is one access per cycle; back-to-back grants to the same or different ports are legal.
- Requester rule: a port holds req and its payload stable until gnt. The arbiter does not check this.
- Simultaneous events:
  - All ports requesting with no lock: strict rotation, one grant per cycle.
  - A lock request on the same cycle as another port's request: the current winner keeps ownership from the next cycle.
- Reset mid-operation: a pending rvalid is dropped and never delivered. Requesters must discard outstanding transactions on reset.

Decomposition:
- Package tcm_arb_pkg holds:
  - the port index type (logic [$clog2(NUM_PORTS_MAX)-1:0], with NUM_PORTS_MAX=8);
  - a response record {valid, we, err};
  - helper function is_misaligned(addr, DATA_WIDTH).
- Sub-module tcm_rr_arb: parameterised round-robin priority picker. Inputs are the req vector, rr_ptr and a lock/owner override; outputs are the one-hot grant and the winner index. It is combinational; the top level holds all state.

Test Plan:
- Single read: port0 reads addr 0x0040 holding 0xDEADBEEF → gnt_o=01 in the same cycle, rvalid_o=01 next cycle, rdata_o=0xDEADBEEF.
- Contention: both ports request continuously for 6 cycles with rr_ptr=0 → grant sequence 01,10,01,10,01,10. Each rvalid follows one cycle later to the matching port.
- Lock burst: port1 writes 4 words at 0x100..0x10C with lock_i[1]=1 while port0 requests → port1 gets 4 consecutive grants; port0 is granted on cycle 5; memory reads back the written values.
- Byte write: port0 writes 0x11223344 to 0x0200 with be=0b0010 over 0xFFFFFFFF → a subsequent read returns 0xFFFF33FF.
- Misaligned: port1 reads addr 0x0003 → gnt_o=10, tcm_en_o=0, and next cycle rvalid_o=10, err_o=10, rdata_o=0.
- Reset mid-op: rst_ni is pulled low in the cycle between a gnt and its rvalid → rvalid_o stays 0 and rr_ptr=0; after release, port1 and port0 requesting together grants port0 first.
